// File: rtl/mvm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mvm_pkg
//  Purpose  : Shared types and helpers for the mvm_row_sequencer slice.
//             - mvm_state_e : sequencer FSM state encoding
//             - mvm_vecw()  : packed vector width from element width
//             - mvm_idxw()  : row index width from row count (minimum 1)
//             - mvm_entry_t : result FIFO entry {result, idx} at the default
//                             configuration (OWIDTH=32, ROWS up to 256)
//  Revision : 1.0  initial release
// ============================================================================
package mvm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } mvm_state_e;

  // Eight signed elements are packed per vector, element 0 in the LSBs.
  function automatic int mvm_vecw(input int iwidth);
    return 8 * iwidth;
  endfunction

  // A single-row job still needs a one-bit index field.
  function automatic int mvm_idxw(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

  typedef struct packed {
    logic [31:0] result;
    logic [7:0]  idx;
  } mvm_entry_t;

endpackage
`default_nettype wire

// File: rtl/mvm_row_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : mvm_row_sequencer_if
//  Purpose  : Bundles the job, row-memory, dot8 and result-stream signals of
//             mvm_row_sequencer.
//  Ports    : master = sequencer side, slave = environment side
//             job     : start, vec_in, busy, done, err
//             row mem : row_rd, row_addr, row_data
//             dot8    : dot_vec0, dot_vec1, dot_ivalid, dot_result, dot_ovalid
//             results : res_data, res_idx, res_valid, res_ready
//  Revision : 1.0  initial release
// ============================================================================
interface mvm_row_sequencer_if #(
  parameter int VECW   = 64,
  parameter int OWIDTH = 32,
  parameter int IDXW   = 3
);
  logic              start;
  logic [VECW-1:0]   vec_in;
  logic              busy;
  logic              done;
  logic              err;
  logic              row_rd;
  logic [IDXW-1:0]   row_addr;
  logic [VECW-1:0]   row_data;
  logic [VECW-1:0]   dot_vec0;
  logic [VECW-1:0]   dot_vec1;
  logic              dot_ivalid;
  logic [OWIDTH-1:0] dot_result;
  logic              dot_ovalid;
  logic [OWIDTH-1:0] res_data;
  logic [IDXW-1:0]   res_idx;
  logic              res_valid;
  logic              res_ready;

  modport master (
    input  start, vec_in, row_data, dot_result, dot_ovalid, res_ready,
    output busy, done, err, row_rd, row_addr, dot_vec0, dot_vec1, dot_ivalid,
           res_data, res_idx, res_valid
  );

  modport slave (
    output start, vec_in, row_data, dot_result, dot_ovalid, res_ready,
    input  busy, done, err, row_rd, row_addr, dot_vec0, dot_vec1, dot_ivalid,
           res_data, res_idx, res_valid
  );
endinterface
`default_nettype wire

// File: rtl/mvm_result_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : mvm_result_fifo
//  Purpose  : Synchronous FIFO for dot8 results. The head is read straight
//             from the storage flops through the registered read pointer, so
//             a pushed entry appears at the head one cycle after the push.
//  Ports    : clk, rst (sync, active-low)
//             push, push_data : write side (ignored when full without a pop)
//             pop             : read side (ignored when empty)
//             head_data       : oldest entry
//             full, empty, count
//  Revision : 1.0  initial release
// ============================================================================
module mvm_result_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [PW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]               rd_ptr_q, rd_ptr_d;
  logic [PW:0]                 count_q, count_d;
  logic                        do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    // A full FIFO can still accept when the head leaves in the same cycle.
    do_push  = push && ((count_q != FULL_CNT) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign count     = count_q;

endmodule
`default_nettype wire

// File: rtl/mvm_row_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : mvm_row_sequencer
//  Purpose  : Issue-side sequencer for the dot8 datapath. A job latches the
//             input vector, streams ROWS rows from a synchronous row memory
//             into dot8 and returns the results in row order over a
//             valid/ready stream tagged with the row index.
//  Ports    : clk, rst (sync, active-low, shared with dot8)
//             bus (master): start/vec_in/busy/done/err job control,
//             row_rd/row_addr/row_data row memory, dot_* dot8 interface,
//             res_data/res_idx/res_valid/res_ready result stream
//  Revision : 1.0  initial release
// ============================================================================
module mvm_row_sequencer
  import mvm_pkg::*;
#(
  parameter int IWIDTH     = 8,
  parameter int OWIDTH     = 32,
  parameter int ROWS       = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  mvm_row_sequencer_if.master bus
);
  localparam int VECW = mvm_vecw(IWIDTH);
  localparam int IDXW = mvm_idxw(ROWS);
  localparam int CNTW = $clog2(ROWS + 1);
  localparam int EW   = OWIDTH + IDXW;
  localparam int FCW  = $clog2(FIFO_DEPTH) + 1;

  localparam logic [1:0] S_IDLE  = 2'(ST_IDLE);
  localparam logic [1:0] S_ISSUE = 2'(ST_ISSUE);
  localparam logic [1:0] S_DRAIN = 2'(ST_DRAIN);

  localparam logic [CNTW-1:0] LAST_ROW = CNTW'(ROWS - 1);
  localparam logic [CNTW-1:0] ALL_ROWS = CNTW'(ROWS);

  logic [1:0]      state_q, state_d;
  logic [CNTW-1:0] iss_cnt_q, iss_cnt_d;
  logic [CNTW-1:0] ret_cnt_q, ret_cnt_d;
  logic [CNTW-1:0] pop_cnt_q, pop_cnt_d;
  logic [VECW-1:0] vec_q, vec_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            ivalid_q, ivalid_d;

  logic [CNTW-1:0] credit;
  logic            row_rd;
  logic [IDXW-1:0] row_addr;
  logic            last_issue;
  logic            pop;
  logic            pop_last;
  logic            room;
  logic            accept;
  logic [EW-1:0]   push_data;
  logic [EW-1:0]   head_data;
  logic            fifo_full;
  logic            fifo_empty;
  logic [FCW-1:0]  fifo_count;

  always_comb begin
    // Rows in flight plus rows buffered; capping this at FIFO_DEPTH reserves
    // a FIFO slot for every result before its row is even read.
    credit     = iss_cnt_q - pop_cnt_q;
    row_rd     = (state_q == S_ISSUE) && (32'(credit) < 32'(FIFO_DEPTH));
    row_addr   = row_rd ? iss_cnt_q[IDXW-1:0] : '0;
    last_issue = row_rd && (iss_cnt_q == LAST_ROW);
    pop        = !fifo_empty && bus.res_ready;
    pop_last   = pop && (pop_cnt_q == LAST_ROW);
    room       = !fifo_full || pop;
    // A result is only legal when a row is outstanding; anything else is
    // flagged and discarded so the row/idx pairing never slips.
    accept     = bus.dot_ovalid && (state_q != S_IDLE) &&
                 (ret_cnt_q != iss_cnt_q) && room;
    push_data  = {bus.dot_result, ret_cnt_q[IDXW-1:0]};

    state_d   = state_q;
    iss_cnt_d = row_rd ? iss_cnt_q + 1'b1 : iss_cnt_q;
    ret_cnt_d = accept ? ret_cnt_q + 1'b1 : ret_cnt_q;
    pop_cnt_d = pop    ? pop_cnt_q + 1'b1 : pop_cnt_q;
    vec_d     = vec_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q | (bus.dot_ovalid && !accept);
    ivalid_d  = row_rd;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          vec_d     = bus.vec_in;
          iss_cnt_d = '0;
          ret_cnt_d = '0;
          pop_cnt_d = '0;
          busy_d    = 1'b1;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (last_issue) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Stays here for the done cycle so a new start lands one cycle later.
        if ((pop_cnt_q == ALL_ROWS) && (fifo_count == '0)) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (pop_last && (state_q != S_IDLE)) begin
      done_d = 1'b1;
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      iss_cnt_q <= '0;
      ret_cnt_q <= '0;
      pop_cnt_q <= '0;
      vec_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ivalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      iss_cnt_q <= iss_cnt_d;
      ret_cnt_q <= ret_cnt_d;
      pop_cnt_q <= pop_cnt_d;
      vec_q     <= vec_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      ivalid_q  <= ivalid_d;
    end
  end

  mvm_result_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .push_data (push_data),
    .pop       (pop),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.row_rd     = row_rd;
  assign bus.row_addr   = row_addr;
  assign bus.dot_vec0   = bus.row_data;
  assign bus.dot_vec1   = vec_q;
  assign bus.dot_ivalid = ivalid_q;
  assign bus.res_valid  = !fifo_empty;
  assign bus.res_data   = head_data[EW-1:IDXW];
  assign bus.res_idx    = head_data[IDXW-1:0];

endmodule
`default_nettype wire

// File: tb/tb_mvm_row_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mvm_row_sequencer
//  Purpose  : Self-checking bench for mvm_row_sequencer with a row memory
//             model, a two-cycle dot8 model and a result scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mvm_row_sequencer;
  localparam int IWIDTH     = 8;
  localparam int OWIDTH     = 32;
  localparam int ROWS       = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int VECW       = 8 * IWIDTH;
  localparam int IDXW       = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mvm_row_sequencer_if #(.VECW(VECW), .OWIDTH(OWIDTH), .IDXW(IDXW)) bus ();

  mvm_row_sequencer #(
    .IWIDTH(IWIDTH), .OWIDTH(OWIDTH), .ROWS(ROWS), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [OWIDTH-1:0] dotf(input logic [VECW-1:0] a, input logic [VECW-1:0] b);
    logic signed [OWIDTH-1:0] s;
    logic signed [7:0] ea, eb;
    s = '0;
    for (int k = 0; k < 8; k++) begin
      ea = a[k*8 +: 8];
      eb = b[k*8 +: 8];
      s  = s + ea * eb;
    end
    return s;
  endfunction

  // Row memory: data one cycle after the read strobe, zero otherwise.
  logic [VECW-1:0] mem [ROWS];
  always @(posedge clk) bus.row_data <= bus.row_rd ? mem[bus.row_addr] : '0;

  // dot8 model: two-cycle latency, reset together with the sequencer.
  logic [1:0]        vpipe;
  logic [OWIDTH-1:0] rpipe0, rpipe1;
  logic              inj = 1'b0;
  always @(posedge clk) begin
    if (!rst) begin
      vpipe  <= '0;
      rpipe0 <= '0;
      rpipe1 <= '0;
    end else begin
      vpipe  <= {vpipe[0], bus.dot_ivalid};
      rpipe0 <= dotf(bus.dot_vec0, bus.dot_vec1);
      rpipe1 <= rpipe0;
    end
  end
  assign bus.dot_ovalid = vpipe[1] | inj;
  assign bus.dot_result = rpipe1;

  typedef struct {
    logic [OWIDTH-1:0] res;
    logic [IDXW-1:0]   idx;
  } exp_t;
  exp_t sbq[$];

  int cyc = 0;
  int last_pop_cyc = 0;
  int job_pops = 0;
  int ivalid_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t mon_e;
  always @(negedge clk) begin
    if (rst) begin
      if (bus.dot_ivalid) ivalid_cnt++;
      if (bus.res_valid && bus.res_ready) begin
        if (sbq.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_result: got idx %0d data %0h, expected no result",
                   bus.res_idx, bus.res_data);
        end else begin
          mon_e = sbq.pop_front();
          chk("result", {bus.res_idx, bus.res_data}, {mon_e.idx, mon_e.res});
        end
        job_pops++;
        last_pop_cyc = cyc;
      end
    end
  end

  typedef struct packed {
    logic [VECW-1:0]                 vec;
    logic [ROWS-1:0][VECW-1:0]       rows;
    logic [ROWS-1:0][OWIDTH-1:0]     exp;
  } job_t;
  job_t jobs [5];

  // Loads the rows, queues the expected results and starts the job; then
  // checks the first-issue timing on cycles 1 and 2 after start.
  task automatic start_job(input int j);
    for (int r = 0; r < ROWS; r++) begin
      mem[r] = jobs[j].rows[r];
      sbq.push_back('{jobs[j].exp[r], IDXW'(r)});
    end
    job_pops = 0;
    @(posedge clk); #1;
    bus.vec_in = jobs[j].vec;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.vec_in = ~jobs[j].vec;
    @(negedge clk);
    chk("c1_busy_rd_addr_iv", {bus.busy, bus.row_rd, bus.row_addr, bus.dot_ivalid}, {1'b1, 1'b1, 3'd0, 1'b0});
    @(negedge clk);
    chk("c2_ivalid", bus.dot_ivalid, 1'b1);
    chk("c2_vec1", bus.dot_vec1, jobs[j].vec);
  endtask

  task automatic wait_done(input string tag);
    int  n;
    bit  seen;
    n = 0;
    seen = 1'b0;
    while (n < 400 && !seen) begin
      @(negedge clk);
      n++;
      if (bus.done) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, seen, 1'b1);
    if (seen) begin
      chk({tag, "_busy_with_done"}, bus.busy, 1'b0);
      chk({tag, "_pops"}, job_pops, ROWS);
      chk({tag, "_done_lat"}, cyc - last_pop_cyc, 1);
      chk({tag, "_err"}, bus.err, 1'b0);
    end
    chk({tag, "_sb_empty"}, sbq.size(), 0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {bus.done, bus.busy}, 2'b00);
  endtask

  initial begin
    bit found;
    int n;

    for (int r = 0; r < ROWS; r++) begin
      jobs[0].rows[r] = {8{8'(r + 1)}};
      jobs[0].exp[r]  = OWIDTH'(8 * (r + 1));
      jobs[1].rows[r] = (r == 0) ? 64'h0101020304050607 : 64'h0;
      jobs[1].exp[r]  = (r == 0) ? 32'd169 : 32'd0;
      jobs[2].rows[r] = {8{8'h02}};
      jobs[2].exp[r]  = 32'hFFFFFFF0;
      jobs[3].rows[r] = {$urandom(), $urandom()};
      jobs[4].rows[r] = {$urandom(), $urandom()};
    end
    jobs[0].vec = {8{8'h01}};
    jobs[1].vec = 64'h0102030405060708;
    jobs[2].vec = {8{8'hFF}};
    jobs[3].vec = {$urandom(), $urandom()};
    jobs[4].vec = {$urandom(), $urandom()};
    for (int r = 0; r < ROWS; r++) begin
      jobs[3].exp[r] = dotf(jobs[3].rows[r], jobs[3].vec);
      jobs[4].exp[r] = dotf(jobs[4].rows[r], jobs[4].vec);
    end

    bus.start     = 1'b0;
    bus.vec_in    = '0;
    bus.res_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs",
        {bus.busy, bus.done, bus.err, bus.row_rd, bus.row_addr, bus.dot_ivalid,
         bus.res_valid, bus.res_idx, bus.res_data, bus.dot_vec1}, 128'h0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Table-driven jobs with the result stream always ready.
    for (int j = 0; j < 3; j++) begin
      start_job(j);
      wait_done($sformatf("job%0d", j));
    end

    // Backpressure: credit stalls issue after FIFO_DEPTH rows.
    bus.res_ready = 1'b0;
    ivalid_cnt    = 0;
    start_job(4);
    repeat (30) @(negedge clk);
    chk("bp_ivalid_pulses", ivalid_cnt, FIFO_DEPTH);
    chk("bp_stalled", {bus.row_rd, bus.res_valid, bus.busy, bus.res_idx}, {1'b0, 1'b1, 1'b1, 3'd0});
    @(posedge clk); #1;
    bus.res_ready = 1'b1;
    wait_done("backpressure");

    // Start while busy is ignored; a stray ovalid in IDLE sets err only.
    start_job(3);
    @(posedge clk); #1;
    bus.start  = 1'b1;
    bus.vec_in = jobs[4].vec;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    wait_done("busy_start");
    chk("busy_start_vec_kept", bus.dot_vec1, jobs[3].vec);
    @(posedge clk); #1;
    inj = 1'b1;
    @(posedge clk); #1;
    inj = 1'b0;
    @(negedge clk);
    chk("spurious_err", {bus.err, bus.res_valid, bus.busy}, {1'b1, 1'b0, 1'b0});
    repeat (3) @(negedge clk);
    chk("spurious_not_pushed", {bus.err, bus.res_valid}, {1'b1, 1'b0});

    // Reset while draining, then a fresh job.
    start_job(0);
    found = 1'b0;
    n = 0;
    while (!found && n < 100) begin
      @(negedge clk);
      n++;
      if (bus.row_rd && bus.row_addr == 3'd7) found = 1'b1;
    end
    chk("last_issue_seen", found, 1'b1);
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sbq.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("reset_mid_drain",
        {bus.busy, bus.done, bus.err, bus.row_rd, bus.row_addr, bus.dot_ivalid,
         bus.res_valid, bus.res_idx, bus.res_data, bus.dot_vec1}, 128'h0);
    bus.res_ready = 1'b1;
    start_job(3);
    wait_done("after_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
